mainband_pattern_comparator: RTL and testbench
==============================================

# mainband_pattern_comparator

RX-side mainband pattern comparator for the TX-initiated point test. It is driven by the point-test RX controller through a 2-bit control word and a valid-train enable. It checks received lane data against a locally generated LFSR or per-lane-ID pattern, or checks the valid lane against the valtrain pattern. After a fixed number of words it returns a per-lane pass/fail vector with a one-cycle acknowledge.

## Interface
Parameters:
- NUM_LANES, 16, number of data lanes; one result bit per lane
- WORD_W, 16, bits per lane per i_data_valid beat
- NUM_WORDS, 128, beats compared per test (≥2)
- ERR_W, 8, per-lane error counter width (saturating)
- ERR_THRESHOLD, 4, lane passes if error count ≤ this
- LFSR_SEED, 23'h1DBFBC, LFSR seed loaded on clear

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- i_mainband_pattern_compartor_cw  in  2  00 idle, 01 clear, 10 LFSR compare, 11 per-lane-ID compare
- i_comparison_valid_en  in  1  valtrain compare enable; used only when cw=00
- i_data_valid  in  1  beat strobe for i_lane_data / i_valid_lane
- i_lane_data  in  NUM_LANES*WORD_W  lane L occupies bits [L*WORD_W +: WORD_W]
- i_valid_lane  in  8  valid-lane bits for this beat
- o_comparison_results  out  NUM_LANES  1 = pass
- o_comparison_ack  out  1  one-cycle done pulse
- o_busy  out  1  high in COMPARE

## Operation
- FSM states: IDLE, CLEAR, COMPARE, DONE.
- From any state, cw=01 goes to CLEAR on the next edge.
- CLEAR actions, every cycle while in CLEAR:
  - LFSR := LFSR_SEED
  - error counters, beat counter and results := 0
  - ack := 0
- CLEAR → COMPARE when cw∈{10,11}, or when cw=00 and i_comparison_valid_en=1. Otherwise stay in CLEAR.
- Mode is latched on the CLEAR→COMPARE edge:
  - cw=10 → LFSR mode
  - cw=11 → ID mode
  - else → VALTRAIN mode
- COMPARE: each beat with i_data_valid=1 is compared on that edge.
  - LFSR mode: expected word for every lane = the next WORD_W serial output bits of the LFSR (first bit in bit 0).
    - Fibonacci LFSR, polynomial x^23+x^21+x^16+x^8+x^5+x^2+1.
    - Advances WORD_W steps per valid beat only; holds otherwise.
    - Must match the mainband pattern generator bit-for-bit.
  - ID mode: expected word for lane L = {4'hA, L[7:0], 4'hA}.
  - VALTRAIN mode: expected i_valid_lane = 8'hF0. Lane data is ignored.
  - Error rule: any bit mismatch in a lane's beat adds +1 to that lane's counter. Counters saturate at 2^ERR_W−1. VALTRAIN uses counter 0 only.
  - Beat counter increments per valid beat. The beat with counter = NUM_WORDS−1 is the final beat, and its edge moves the FSM to DONE.
- Abort: in COMPARE, cw=00 with i_comparison_valid_en=0 → IDLE on the next edge.
  - No ack is issued.
  - Results stay 0.
  - A partial beat count is discarded.
- DONE entry (first cycle):
  - Result bit L = (err[L] ≤ ERR_THRESHOLD).
  - In VALTRAIN mode, bit 0 = valid-lane result and bits [NUM_LANES-1:1] = 0.
  - o_comparison_ack = 1 for that cycle only.
- In DONE, results are held and data and beats are ignored. Results are held through DONE, through any later cw=00, and through IDLE, until the next CLEAR or reset.
- A cw change to 10/11 while in DONE or IDLE does nothing; a new test requires CLEAR.
- IDLE → CLEAR only on cw=01.

## Timing
- Reset, synchronous, applied at the first edge with rst_n=0:
  - state=IDLE, LFSR=LFSR_SEED, all counters 0
  - o_comparison_results=0, o_comparison_ack=0, o_busy=0
- Reset mid-COMPARE or in DONE discards everything. No ack is produced.
- Latency:
  - Final beat sampled at edge N.
  - o_comparison_ack and the valid o_comparison_results are visible from edge N+1, ack for exactly one cycle.
- cw=01 at edge N → CLEAR at N+1 → earliest COMPARE at N+2. A beat at edge N+1 (while in CLEAR) is ignored.
- i_data_valid gaps are allowed. The LFSR and beat counter hold during gaps.
- cw=01 in the same cycle as the final beat: CLEAR wins. No ack, results cleared.
- o_busy = (state==COMPARE), registered with the state.

## Test plan
- LFSR clean run: clear, then cw=10, then 128 valid beats of matching LFSR data with 1-cycle gaps every 10 beats → ack 1 cycle after the 128th beat's edge; results=16'hFFFF.
- ID mode errors: cw=11; lane 3 corrupted on 5 beats, lane 7 on 4 beats → results=16'hFFF7 (lane 7 passes at threshold); ack once.
- Valtrain: cw=00, valid_en=1; 6 beats with i_valid_lane=8'hF1, rest 8'hF0 → results=16'h0000. Repeat with 4 bad beats → results=16'h0001.
- Saturation: ID mode, lane 0 wrong on all 128 beats with ERR_W=4 → counter stops at 15; lane 0 fails; no wrap.
- Abort and priority:
  - cw→00 with valid_en=0 after 50 beats → IDLE, no ack, results 0.
  - cw=01 on the final beat edge → no ack, state CLEAR.
- Reset/hold: after DONE with results 16'hFFF7, hold cw=00 for 20 cycles → results unchanged. Assert rst_n=0 for 1 edge → results 0, ack 0, state IDLE.

Source files
------------

// File: rtl/mainband_pattern_comparator.sv
// RX mainband pattern comparator: checks lane data against the LFSR or lane-ID
// pattern, or the valid lane against valtrain, and reports per-lane pass/fail.
module mainband_pattern_comparator #(
  parameter int          NUM_LANES     = 16,
  parameter int          WORD_W        = 16,
  parameter int          NUM_WORDS     = 128,
  parameter int          ERR_W         = 8,
  parameter int          ERR_THRESHOLD = 4,
  parameter logic [22:0] LFSR_SEED     = 23'h1DBFBC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    i_mainband_pattern_compartor_cw,
  input  logic                          i_comparison_valid_en,
  input  logic                          i_data_valid,
  input  logic [NUM_LANES*WORD_W-1:0]   i_lane_data,
  input  logic [7:0]                    i_valid_lane,
  output logic [NUM_LANES-1:0]          o_comparison_results,
  output logic                          o_comparison_ack,
  output logic                          o_busy
);
  localparam int              BEAT_W    = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_WORDS - 1);
  localparam logic [1:0]      CW_IDLE   = 2'b00;
  localparam logic [1:0]      CW_CLEAR  = 2'b01;
  localparam logic [1:0]      CW_LFSR   = 2'b10;
  localparam logic [1:0]      CW_ID     = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_COMPARE, ST_DONE} state_t;
  typedef enum logic [1:0] {MD_LFSR, MD_ID, MD_VALTRAIN} mode_t;

  state_t                state_q;
  mode_t                 mode_q;
  logic [22:0]           lfsr_q, lfsr_d;
  logic [BEAT_W-1:0]     beat_q;
  logic [ERR_W-1:0]      err_q [NUM_LANES];
  logic [ERR_W-1:0]      err_d [NUM_LANES];
  logic [NUM_LANES-1:0]  pass_d;
  logic [NUM_LANES-1:0]  results_q;
  logic                  ack_q, busy_q;
  logic [WORD_W-1:0]     lfsr_word;
  logic [WORD_W-1:0]     lane_word;
  logic                  mism;

  // Fibonacci form of x^23+x^21+x^16+x^8+x^5+x^2+1; serial output is bit 22.
  function automatic logic [22:0] lfsr_step(input logic [22:0] s);
    return {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
  endfunction

  function automatic logic [WORD_W-1:0] id_word(input int lane);
    logic [15:0] p;
    p = {4'hA, 8'(lane), 4'hA};
    return WORD_W'(p);
  endfunction

  always_comb begin
    lfsr_d    = lfsr_q;
    lfsr_word = '0;
    for (int b = 0; b < WORD_W; b++) begin
      lfsr_word[b] = lfsr_d[22];
      lfsr_d       = lfsr_step(lfsr_d);
    end
  end

  always_comb begin
    lane_word = '0;
    mism      = 1'b0;
    pass_d    = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_word = i_lane_data[l*WORD_W +: WORD_W];
      case (mode_q)
        MD_LFSR: mism = (lane_word != lfsr_word);
        MD_ID:   mism = (lane_word != id_word(l));
        default: mism = (l == 0) && (i_valid_lane != 8'hF0);
      endcase
      err_d[l] = err_q[l];
      if (mism && (err_q[l] != {ERR_W{1'b1}}))
        err_d[l] = err_q[l] + 1'b1;
      // Valtrain only ever produces a verdict on bit 0.
      if (mode_q == MD_VALTRAIN && l != 0)
        pass_d[l] = 1'b0;
      else
        pass_d[l] = (int'(err_d[l]) <= ERR_THRESHOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MD_LFSR;
      lfsr_q    <= LFSR_SEED;
      beat_q    <= '0;
      results_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) err_q[l] <= '0;
    end else begin
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      if (i_mainband_pattern_compartor_cw == CW_CLEAR || state_q == ST_CLEAR) begin
        lfsr_q    <= LFSR_SEED;
        beat_q    <= '0;
        results_q <= '0;
        for (int l = 0; l < NUM_LANES; l++) err_q[l] <= '0;
      end
      if (i_mainband_pattern_compartor_cw == CW_CLEAR) begin
        state_q <= ST_CLEAR;
      end else begin
        case (state_q)
          ST_CLEAR: begin
            if (i_mainband_pattern_compartor_cw != CW_IDLE || i_comparison_valid_en) begin
              state_q <= ST_COMPARE;
              busy_q  <= 1'b1;
              if (i_mainband_pattern_compartor_cw == CW_LFSR)    mode_q <= MD_LFSR;
              else if (i_mainband_pattern_compartor_cw == CW_ID) mode_q <= MD_ID;
              else                                               mode_q <= MD_VALTRAIN;
            end
          end
          ST_COMPARE: begin
            if (i_mainband_pattern_compartor_cw == CW_IDLE && !i_comparison_valid_en) begin
              state_q <= ST_IDLE;
              beat_q  <= '0;
              for (int l = 0; l < NUM_LANES; l++) err_q[l] <= '0;
            end else begin
              busy_q <= 1'b1;
              if (i_data_valid) begin
                lfsr_q <= lfsr_d;
                beat_q <= beat_q + 1'b1;
                err_q  <= err_d;
                if (beat_q == LAST_BEAT) begin
                  state_q   <= ST_DONE;
                  busy_q    <= 1'b0;
                  results_q <= pass_d;
                  ack_q     <= 1'b1;
                end
              end
            end
          end
          ST_DONE: begin
            if (i_mainband_pattern_compartor_cw == CW_IDLE) state_q <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_comparison_results = results_q;
  assign o_comparison_ack     = ack_q;
  assign o_busy               = busy_q;
endmodule

// File: tb/tb_mainband_pattern_comparator.sv
// Bench for mainband_pattern_comparator: directed and randomized tests checked
// against a sequence-level reference model.
module tb_mainband_pattern_comparator;
  localparam int          NL   = 16;
  localparam int          WW   = 16;
  localparam int          NW   = 128;
  localparam int          EW   = 4;
  localparam int          THR  = 4;
  localparam int          YLEN = NW*WW + 23;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        cw = 2'b00;
  logic              ven = 1'b0;
  logic              dv = 1'b0;
  logic [NL*WW-1:0]  data = '0;
  logic [7:0]        vl = 8'hF0;
  logic [NL-1:0]     results;
  logic              ack;
  logic              busy;

  int total = 0;
  int bad = 0;

  bit          yseq [YLEN];
  logic [15:0] bad_tab [NW];
  bit          badv_tab [NW];
  int          cnt [NL];

  mainband_pattern_comparator #(
    .NUM_LANES(NL), .WORD_W(WW), .NUM_WORDS(NW), .ERR_W(EW),
    .ERR_THRESHOLD(THR), .LFSR_SEED(23'h1DBFBC)
  ) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .i_mainband_pattern_compartor_cw (cw),
    .i_comparison_valid_en           (ven),
    .i_data_valid                    (dv),
    .i_lane_data                     (data),
    .i_valid_lane                    (vl),
    .o_comparison_results            (results),
    .o_comparison_ack                (ack),
    .o_busy                          (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial PRBS as a linear recurrence on the output bit stream.
  task automatic build_prbs();
    logic [22:0] seed;
    seed = 23'h1DBFBC;
    for (int j = 0; j < 23; j++) yseq[j] = seed[22-j];
    for (int n = 0; n + 23 < YLEN; n++)
      yseq[n+23] = yseq[n] ^ yseq[n+2] ^ yseq[n+7] ^ yseq[n+15] ^ yseq[n+18] ^ yseq[n+21];
  endtask

  function automatic logic [15:0] exp_word(input int mode, input int k, input int lane);
    logic [15:0] w;
    w = '0;
    if (mode == 2) begin
      for (int b = 0; b < WW; b++) w[b] = yseq[k*WW + b];
    end else begin
      w = {4'hA, 8'(lane), 4'hA};
    end
    return w;
  endfunction

  function automatic logic [15:0] exp_res(input int mode);
    logic [15:0] r;
    int sat;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      sat = (cnt[l] > (2**EW - 1)) ? (2**EW - 1) : cnt[l];
      if (mode == 0) r[l] = (l == 0) && (sat <= THR);
      else           r[l] = (sat <= THR);
    end
    return r;
  endfunction

  task automatic reset_model();
    for (int l = 0; l < NL; l++) cnt[l] = 0;
  endtask

  task automatic clear_tabs();
    for (int k = 0; k < NW; k++) begin
      bad_tab[k]  = '0;
      badv_tab[k] = 1'b0;
    end
  endtask

  task automatic random_data();
    for (int l = 0; l < NL; l++) data[l*WW +: WW] = 16'($urandom);
  endtask

  // Clear, then enter the mode; a beat presented during CLEAR must be ignored.
  task automatic start_test(input logic [1:0] mode_cw);
    reset_model();
    cw  = 2'b01;
    ven = 1'b0;
    step();
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_results", 32'(results), 32'd0);
    cw  = mode_cw;
    ven = (mode_cw == 2'b00);
    dv  = 1'b1;
    random_data();
    vl  = 8'($urandom);
    step();
    dv  = 1'b0;
    chk("enter_busy", 32'(busy), 32'd1);
  endtask

  task automatic beat(input int mode, input int k, input logic [15:0] badl, input bit badv);
    logic [15:0] w;
    for (int l = 0; l < NL; l++) begin
      w = exp_word(mode, k, l);
      if (badl[l]) w = w ^ 16'($urandom_range(1, 65535));
      data[l*WW +: WW] = w;
    end
    if (mode == 0) random_data();
    vl = badv ? (8'hF0 ^ 8'($urandom_range(1, 255))) : 8'hF0;
    dv = 1'b1;
    step();
    dv = 1'b0;
    for (int l = 0; l < NL; l++) begin
      if (mode == 0) begin
        if (l == 0 && badv) cnt[0]++;
      end else if (badl[l]) begin
        cnt[l]++;
      end
    end
  endtask

  task automatic run_beats(input int mode, input int n, input int gapmode);
    logic [15:0] er;
    for (int k = 0; k < n; k++) begin
      beat(mode, k, bad_tab[k], badv_tab[k]);
      if (k != NW-1) chk("ack_early", 32'(ack), 32'd0);
      if ((gapmode == 1 && (k % 10) == 9) || (gapmode == 2 && $urandom_range(0, 3) == 0)) begin
        random_data();
        step();
      end
    end
    if (n == NW) begin
      er = exp_res(mode);
      chk("done_ack", 32'(ack), 32'd1);
      chk("done_results", 32'(results), 32'(er));
      chk("done_busy", 32'(busy), 32'd0);
      dv = 1'b1;
      random_data();
      step();
      dv = 1'b0;
      chk("ack_single", 32'(ack), 32'd0);
      chk("done_hold", 32'(results), 32'(er));
    end
  endtask

  initial begin
    int m;
    build_prbs();
    clear_tabs();
    reset_model();

    // Reset state
    rst_n = 1'b0;
    step();
    chk("rst_results", 32'(results), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // LFSR clean run with gaps every 10 beats
    start_test(2'b10);
    clear_tabs();
    run_beats(2, NW, 1);
    chk("lfsr_clean", 32'(results), 32'h0000FFFF);

    // ID mode: lane 3 bad on 5 beats, lane 7 on 4 beats
    start_test(2'b11);
    clear_tabs();
    bad_tab[5][3] = 1'b1;  bad_tab[20][3] = 1'b1;  bad_tab[40][3] = 1'b1;
    bad_tab[80][3] = 1'b1; bad_tab[127][3] = 1'b1;
    bad_tab[0][7] = 1'b1;  bad_tab[33][7] = 1'b1;  bad_tab[66][7] = 1'b1;
    bad_tab[99][7] = 1'b1;
    run_beats(3, NW, 0);
    chk("id_errors", 32'(results), 32'h0000FFF7);

    // Hold through cw=00 and IDLE; mode commands in IDLE are ignored
    cw = 2'b00; ven = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_ack", 32'(ack), 32'd0);
    end
    chk("hold_results", 32'(results), 32'h0000FFF7);
    cw = 2'b10;
    step();
    chk("idle_cw10_busy", 32'(busy), 32'd0);
    chk("idle_cw10_results", 32'(results), 32'h0000FFF7);
    cw = 2'b00;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("reset_results", 32'(results), 32'd0);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Valtrain: 6 bad beats fail, 4 bad beats pass
    start_test(2'b00);
    clear_tabs();
    badv_tab[3] = 1'b1; badv_tab[17] = 1'b1; badv_tab[50] = 1'b1;
    badv_tab[90] = 1'b1; badv_tab[100] = 1'b1; badv_tab[127] = 1'b1;
    run_beats(0, NW, 0);
    chk("vt_fail", 32'(results), 32'h00000000);
    start_test(2'b00);
    clear_tabs();
    badv_tab[1] = 1'b1; badv_tab[2] = 1'b1; badv_tab[60] = 1'b1; badv_tab[126] = 1'b1;
    run_beats(0, NW, 0);
    chk("vt_pass", 32'(results), 32'h00000001);

    // Saturation: lane 0 wrong on every beat must not wrap back to a pass
    start_test(2'b11);
    clear_tabs();
    for (int k = 0; k < NW; k++) bad_tab[k][0] = 1'b1;
    run_beats(3, NW, 0);
    chk("saturate", 32'(results), 32'h0000FFFE);

    // Abort after 50 beats
    start_test(2'b10);
    clear_tabs();
    run_beats(2, 50, 0);
    cw = 2'b00; ven = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_results", 32'(results), 32'd0);
    for (int i = 0; i < 100; i++) begin
      dv = 1'b1;
      random_data();
      step();
      chk("abort_noack", 32'(ack), 32'd0);
    end
    dv = 1'b0;

    // CLEAR wins over the final beat; the following test starts from zero
    start_test(2'b11);
    clear_tabs();
    run_beats(3, NW-1, 0);
    cw = 2'b01;
    beat(3, NW-1, 16'h0000, 1'b0);
    chk("clrfinal_ack", 32'(ack), 32'd0);
    chk("clrfinal_busy", 32'(busy), 32'd0);
    chk("clrfinal_results", 32'(results), 32'd0);
    reset_model();
    cw = 2'b11;
    step();
    chk("clrfinal_compare", 32'(busy), 32'd1);
    run_beats(3, NW, 0);

    // Reset mid-compare
    start_test(2'b10);
    clear_tabs();
    run_beats(2, 30, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_results", 32'(results), 32'd0);
    for (int i = 0; i < 100; i++) begin
      dv = 1'b1;
      step();
      chk("midrst_noack", 32'(ack), 32'd0);
    end
    dv = 1'b0;

    // Randomized tests
    for (int it = 0; it < 6; it++) begin
      m = $urandom_range(0, 2);
      if (m == 1) m = 3;
      start_test(2'(m));
      for (int k = 0; k < NW; k++) begin
        for (int l = 0; l < NL; l++) bad_tab[k][l] = ($urandom_range(0, 39) == 0);
        badv_tab[k] = ($urandom_range(0, 29) == 0);
      end
      run_beats(m, NW, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
